// File: rtl/wb_arb_pkg.sv
// Shared defaults and types for the register-file write-port arbiter.
package wb_arb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    // A one-entry FIFO still needs a one-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline/multi-cycle unit (master) and the write-port arbiter (slave).
interface wb_port_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
);

    logic                   wb0_en;
    logic [ADDR_W-1:0]      wb0_rd;
    logic [DATA_W-1:0]      wb0_data;
    logic                   mc_valid;
    logic                   mc_ready;
    logic [ADDR_W-1:0]      mc_rd;
    logic [DATA_W-1:0]      mc_data;
    logic                   rf_wb_en;
    logic [ADDR_W-1:0]      rf_rd_index;
    logic [DATA_W-1:0]      rf_wb_data;
    logic [2**ADDR_W-1:0]   pending_mask;
    logic                   stall_o;

    modport master (
        output wb0_en, wb0_rd, wb0_data, mc_valid, mc_rd, mc_data,
        input  mc_ready, rf_wb_en, rf_rd_index, rf_wb_data, pending_mask, stall_o
    );

    modport slave (
        input  wb0_en, wb0_rd, wb0_data, mc_valid, mc_rd, mc_data,
        output mc_ready, rf_wb_en, rf_rd_index, rf_wb_data, pending_mask, stall_o
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO for multi-cycle results; exposes per-entry valid/rd for the pending mask.
module wb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [ADDR_W-1:0]            i_rd,
    input  logic [DATA_W-1:0]            i_data,
    input  logic                         i_pop,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [ADDR_W-1:0]            o_head_rd,
    output logic [DATA_W-1:0]            o_head_data,
    output logic [DEPTH-1:0]             o_ent_vld,
    output logic [DEPTH-1:0][ADDR_W-1:0] o_ent_rd
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]             r_wr_ptr;
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [CNT_W-1:0]             r_count;
    logic [DEPTH-1:0]             r_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] r_rd_mem;
    logic [DATA_W-1:0]            r_data_mem [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Read and write slots never coincide while both are active (empty/full exclude it).
            for (int i = 0; i < DEPTH; i++) begin
                if (i_pop && (r_rd_ptr == PTR_W'(i)))  r_vld[i] <= 1'b0;
                if (i_push && (r_wr_ptr == PTR_W'(i))) r_vld[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_rd_mem[r_wr_ptr]   <= i_rd;
            r_data_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_head_rd   = r_rd_mem[r_rd_ptr];
    assign o_head_data = r_data_mem[r_rd_ptr];
    assign o_ent_vld   = r_vld;
    assign o_ent_rd    = r_rd_mem;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority, multi-cycle results queue and
// drain into idle slots; a starvation counter requests a WB bubble when the queue is stuck.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W       = WB_DATA_W,
    parameter int ADDR_W       = WB_ADDR_W,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);

    localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

    logic                         w_a_busy;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_full;
    logic                         w_empty;
    logic [ADDR_W-1:0]            w_head_rd;
    logic [DATA_W-1:0]            w_head_data;
    logic [DEPTH-1:0]             w_ent_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] w_ent_rd;
    logic [2**ADDR_W-1:0]         w_mask;
    logic [SCNT_W-1:0]            r_starve_cnt;

    assign w_a_busy     = bus.wb0_en && (bus.wb0_rd != '0);
    assign w_pop        = !rst && !w_a_busy && !w_empty;
    assign bus.mc_ready = !rst && !w_full;
    // Results targeting x0 are accepted but never enqueued.
    assign w_push       = bus.mc_valid && bus.mc_ready && (bus.mc_rd != '0);

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_rd        (bus.mc_rd),
        .i_data      (bus.mc_data),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .o_ent_vld   (w_ent_vld),
        .o_ent_rd    (w_ent_rd)
    );

    always_comb begin
        bus.rf_wb_en    = 1'b0;
        bus.rf_rd_index = w_head_rd;
        bus.rf_wb_data  = w_head_data;
        if (!rst) begin
            if (w_a_busy) begin
                bus.rf_wb_en    = 1'b1;
                bus.rf_rd_index = bus.wb0_rd;
                bus.rf_wb_data  = bus.wb0_data;
            end else if (!w_empty) begin
                bus.rf_wb_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_pop) begin
            r_starve_cnt <= '0;
        end else if (!w_empty && w_a_busy && (r_starve_cnt != SCNT_W'(STARVE_LIMIT))) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign bus.stall_o = !rst && (r_starve_cnt == SCNT_W'(STARVE_LIMIT));

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_vld[i]) w_mask[w_ent_rd[i]] = 1'b1;
        end
    end

    assign bus.pending_mask = rst ? '0 : w_mask;

    a_no_wb0_during_stall: assert property (@(posedge clk) disable iff (rst)
        !(bus.stall_o && w_a_busy));
    a_no_x0_write: assert property (@(posedge clk) disable iff (rst)
        !(bus.rf_wb_en && (bus.rf_rd_index == '0)));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a queue scoreboard of expected multi-cycle writes.
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    wb_req_t sb[$];
    int      scnt;

    wb_port_arbiter_if #(.DATA_W(WB_DATA_W), .ADDR_W(WB_ADDR_W)) bus ();

    wb_port_arbiter #(
        .DATA_W       (WB_DATA_W),
        .ADDR_W       (WB_ADDR_W),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        bus.wb0_en   = en;
        bus.wb0_rd   = rd;
        bus.wb0_data = data;
    endtask

    task automatic set_mc(input logic vld, input logic [4:0] rd, input logic [31:0] data);
        bus.mc_valid = vld;
        bus.mc_rd    = rd;
        bus.mc_data  = data;
    endtask

    // One cycle: check outputs at the falling edge against the scoreboard, then advance the model.
    task automatic tick(input string tag);
        logic        busy;
        logic        pop;
        logic        rdy;
        logic [31:0] mask;
        wb_req_t     hd;
        @(negedge clk);
        busy = bus.wb0_en && (bus.wb0_rd != 5'd0);
        pop  = 1'b0;
        if (rst) begin
            chk({tag, ".rf_wb_en"},     {63'd0, bus.rf_wb_en}, 64'd0);
            chk({tag, ".mc_ready"},     {63'd0, bus.mc_ready}, 64'd0);
            chk({tag, ".stall_o"},      {63'd0, bus.stall_o},  64'd0);
            chk({tag, ".pending_mask"}, {32'd0, bus.pending_mask}, 64'd0);
            sb.delete();
            scnt = 0;
        end else begin
            rdy  = (sb.size() < DEPTH);
            mask = '0;
            foreach (sb[i]) mask[sb[i].rd] = 1'b1;
            chk({tag, ".mc_ready"},     {63'd0, bus.mc_ready}, {63'd0, rdy});
            chk({tag, ".stall_o"},      {63'd0, bus.stall_o},  {63'd0, (scnt == LIMIT)});
            chk({tag, ".pending_mask"}, {32'd0, bus.pending_mask}, {32'd0, mask});
            if (busy) begin
                chk({tag, ".rf_wb_en"},    {63'd0, bus.rf_wb_en},    64'd1);
                chk({tag, ".rf_rd_index"}, {59'd0, bus.rf_rd_index}, {59'd0, bus.wb0_rd});
                chk({tag, ".rf_wb_data"},  {32'd0, bus.rf_wb_data},  {32'd0, bus.wb0_data});
            end else if (sb.size() > 0) begin
                hd  = sb[0];
                pop = 1'b1;
                chk({tag, ".rf_wb_en"},    {63'd0, bus.rf_wb_en},    64'd1);
                chk({tag, ".rf_rd_index"}, {59'd0, bus.rf_rd_index}, {59'd0, hd.rd});
                chk({tag, ".rf_wb_data"},  {32'd0, bus.rf_wb_data},  {32'd0, hd.data});
            end else begin
                chk({tag, ".rf_wb_en"},    {63'd0, bus.rf_wb_en},    64'd0);
            end
            if (pop) begin
                void'(sb.pop_front());
                scnt = 0;
            end else if ((sb.size() > 0) && busy && (scnt < LIMIT)) begin
                scnt++;
            end
            if (bus.mc_valid && rdy && (bus.mc_rd != 5'd0))
                sb.push_back(wb_req_t'({bus.mc_rd, bus.mc_data}));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        scnt = 0;
        rst  = 1'b1;
        set_wb(1'b1, 5'd4, 32'hDEAD_0004);
        set_mc(1'b0, 5'd0, 32'h0);
        tick("rst0");
        set_wb(1'b0, 5'd0, 32'h0);
        tick("rst1");
        rst = 1'b0;
        tick("idle");

        // Idle pipe: single result drains the next cycle
        set_mc(1'b1, 5'd5, 32'h0000_00A5);
        tick("t1_acc");
        set_mc(1'b0, 5'd0, 32'h0);
        tick("t1_wr");
        tick("t1_after");

        // Collision: wb0 wins, queued results keep their order
        set_wb(1'b1, 5'd3, 32'h0000_0033);
        set_mc(1'b1, 5'd7, 32'h0000_0077);
        tick("t2_c0");
        set_wb(1'b1, 5'd3, 32'h0000_0034);
        set_mc(1'b1, 5'd9, 32'h0000_0099);
        tick("t2_c1");
        set_wb(1'b0, 5'd0, 32'h0);
        set_mc(1'b0, 5'd0, 32'h0);
        tick("t2_d7");
        tick("t2_d9");
        tick("t2_idle");

        // Full: third result held off until a slot frees
        set_wb(1'b1, 5'd1, 32'h0000_1001);
        set_mc(1'b1, 5'd10, 32'h0000_0010);
        tick("t3_a10");
        set_mc(1'b1, 5'd11, 32'h0000_0011);
        tick("t3_a11");
        set_mc(1'b1, 5'd12, 32'h0000_0012);
        set_wb(1'b1, 5'd1, 32'h0000_1002);
        tick("t3_full0");
        set_wb(1'b1, 5'd1, 32'h0000_1003);
        tick("t3_full1");
        set_wb(1'b0, 5'd0, 32'h0);
        tick("t3_pop10");
        tick("t3_acc12");
        set_mc(1'b0, 5'd0, 32'h0);
        tick("t3_d12");
        tick("t3_idle");

        // Starvation: four blocked cycles raise stall_o for one cycle
        set_wb(1'b1, 5'd2, 32'h0000_2000);
        set_mc(1'b1, 5'd14, 32'h0000_0014);
        tick("t4_acc");
        set_mc(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < LIMIT; i++) begin
            set_wb(1'b1, 5'd2, 32'h0000_2001 + i);
            tick("t4_blk");
        end
        set_wb(1'b0, 5'd0, 32'h0);
        tick("t4_stall");
        tick("t4_clear");

        // x0: never written, rd=0 result consumed, queued entry drains under a wb0 rd=0 cycle
        set_wb(1'b1, 5'd0, 32'h0000_BAD0);
        set_mc(1'b1, 5'd0, 32'h0000_BAD1);
        tick("t5_x0");
        set_wb(1'b1, 5'd2, 32'h0000_2100);
        set_mc(1'b1, 5'd20, 32'h0000_0020);
        tick("t5_acc20");
        set_wb(1'b1, 5'd0, 32'h0000_BAD2);
        set_mc(1'b1, 5'd0, 32'h0000_BAD3);
        tick("t5_d20");
        set_wb(1'b0, 5'd0, 32'h0);
        set_mc(1'b0, 5'd0, 32'h0);
        tick("t5_idle");

        // Reset with two queued entries
        set_wb(1'b1, 5'd6, 32'h0000_6000);
        set_mc(1'b1, 5'd21, 32'h0000_0021);
        tick("t6_a21");
        set_mc(1'b1, 5'd22, 32'h0000_0022);
        tick("t6_a22");
        set_wb(1'b0, 5'd0, 32'h0);
        set_mc(1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        tick("t6_rst");
        rst = 1'b0;
        tick("t6_post");
        tick("t6_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
